dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Shares the single-port data RAM between the CPU (o_dm_address/o_wr_Ram/o_rd_Ram side)
//  and a debug/loader host. CPU has fixed priority; the host gets idle RAM cycles.
//  A host starved for MAX_WAIT cycles makes the block freeze the CPU (o_cpu_halt) and serve the host.
//  Sits between cpu, the data RAM and the debug unit at top level.
// PARAMETERS
//  NB_ADDRESS  11  data RAM address width
//  NB_DATA     16  data RAM word width
//  MAX_WAIT    8   blocked host cycles before halt request (>=1); counter is $clog2(MAX_WAIT+1) bits
// PORTS
//  i_clk          in   1           clock, rising edge
//  i_reset        in   1           asynchronous, active-low reset
//  i_cpu_address  in   NB_ADDRESS  CPU data address
//  i_cpu_data     in   NB_DATA     CPU write data
//  i_cpu_wr_Ram   in   1           CPU write strobe
//  i_cpu_rd_Ram   in   1           CPU read strobe
//  o_cpu_data     out  NB_DATA     read data to CPU (= i_ram_data)
//  o_cpu_halt     out  1           registered freeze request to CPU
//  i_dbg_valid    in   1           host request valid
//  i_dbg_we       in   1           1 write, 0 read
//  i_dbg_address  in   NB_ADDRESS  host address
//  i_dbg_data     in   NB_DATA     host write data
//  o_dbg_ready    out  1           host request accepted this cycle
//  o_dbg_rvalid   out  1           one-cycle pulse, o_dbg_rdata valid
//  o_dbg_rdata    out  NB_DATA     registered host read data
//  o_ram_address  out  NB_ADDRESS  RAM address
//  o_ram_data     out  NB_DATA     RAM write data
//  o_ram_we       out  1           RAM write enable
//  o_ram_re       out  1           RAM read enable
//  i_ram_data     in   NB_DATA     RAM read data, valid 1 cycle after o_ram_re
// BEHAVIOUR
//  Reset (i_reset=0, async): state S_IDLE, counter 0, o_cpu_halt 0, o_dbg_rvalid 0,
//   o_dbg_rdata 0, read-pending pipe cleared (reads in flight are dropped, no rvalid).
//  cpu_busy = i_cpu_wr_Ram | i_cpu_rd_Ram, and state != S_HALT.
//  o_dbg_ready = i_dbg_valid & !cpu_busy (combinational). Grant = valid & ready.
//  RAM mux (combinational): cpu_busy -> CPU address/data/strobes; grant -> host address/data,
//   o_ram_we = i_dbg_we, o_ram_re = !i_dbg_we; else all strobes 0, address/data = CPU values.
//  CPU wins any simultaneous access outside S_HALT; CPU strobes are ignored in S_HALT.
//  Host read latency: grant at cycle T -> i_ram_data captured at end of T+1 ->
//   o_dbg_rvalid=1 during T+2. Back-to-back reads allowed, one rvalid per read, in order.
//  FSM:
//   S_IDLE:   i_dbg_valid & cpu_busy -> S_STARVE, counter=1. Otherwise stay.
//   S_STARVE: grant -> S_IDLE, counter=0; !i_dbg_valid -> S_IDLE, counter=0;
//             else counter+1; when counter==MAX_WAIT -> S_HALT, o_cpu_halt=1 next cycle.
//   S_HALT:   o_cpu_halt=1; host granted every valid cycle. When !i_dbg_valid and no
//             read pending -> S_IDLE, o_cpu_halt=0 on the following cycle.
//  CPU contract: while o_cpu_halt=1 the CPU holds state; an access ignored in that
//   window is reissued after release (no CPU access is lost).
//  Counter saturates at MAX_WAIT; never wraps.
//  Reset mid-halt: o_cpu_halt drops asynchronously with reset.
// TESTING
//  1 CPU idle, host write 0x0A5 <= 16'h1234, then host read 0x0A5 -> ready same cycle,
//    o_dbg_rvalid 2 cycles after read grant with o_dbg_rdata=16'h1234.
//  2 CPU write 0x010 and host write 0x010 same cycle -> RAM gets CPU data, o_dbg_ready=0;
//    host granted first cycle CPU strobes low.
//  3 CPU strobes held high, host valid, MAX_WAIT=8 -> o_cpu_halt rises after 8 blocked
//    cycles, host granted in S_HALT, halt drops the cycle after valid falls.
//  4 Four back-to-back host reads 0x000..0x003 (preloaded 1..4) -> four consecutive
//    rvalid pulses, data 1,2,3,4 in order.
//  5 i_reset low for 1 cycle between read grant and rvalid -> no rvalid, halt 0,
//    state S_IDLE, outputs at reset values.
//  6 Host valid drops in S_STARVE before grant -> back to S_IDLE, counter 0, no halt.

Source files
------------

// File: rtl/dm_arbiter.sv
// Data RAM arbiter: the CPU has fixed priority on the single-port RAM. The
// debug/loader host gets the idle cycles. A host that stays blocked for
// MAX_WAIT cycles freezes the CPU until the host finishes its transfers.
module dm_arbiter #(
    parameter int NB_ADDRESS = 11,
    parameter int NB_DATA    = 16,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NB_ADDRESS-1:0] i_cpu_address,
    input  logic [NB_DATA-1:0]    i_cpu_data,
    input  logic                  i_cpu_wr_Ram,
    input  logic                  i_cpu_rd_Ram,
    output logic [NB_DATA-1:0]    o_cpu_data,
    output logic                  o_cpu_halt,
    input  logic                  i_dbg_valid,
    input  logic                  i_dbg_we,
    input  logic [NB_ADDRESS-1:0] i_dbg_address,
    input  logic [NB_DATA-1:0]    i_dbg_data,
    output logic                  o_dbg_ready,
    output logic                  o_dbg_rvalid,
    output logic [NB_DATA-1:0]    o_dbg_rdata,
    output logic [NB_ADDRESS-1:0] o_ram_address,
    output logic [NB_DATA-1:0]    o_ram_data,
    output logic                  o_ram_we,
    output logic                  o_ram_re,
    input  logic [NB_DATA-1:0]    i_ram_data
);

    localparam int NB_CNT = $clog2(MAX_WAIT + 1);
    localparam logic [NB_CNT-1:0] CntMax = NB_CNT'(MAX_WAIT);
    localparam logic [NB_CNT-1:0] CntOne = NB_CNT'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STARVE,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [NB_CNT-1:0]   cnt_q, cnt_d;
    logic                halt_q;
    logic                rdPend_q;
    logic                rvalid_q;
    logic [NB_DATA-1:0]  rdata_q;

    logic cpuBusy;
    logic grant;

    // The CPU only counts as a contender while it is not frozen; any strobe
    // it shows during a halt is dropped and reissued after release.
    assign cpuBusy     = (i_cpu_wr_Ram | i_cpu_rd_Ram) & (state_q != S_HALT);
    assign o_dbg_ready = i_dbg_valid & ~cpuBusy;
    assign grant       = i_dbg_valid & o_dbg_ready;

    assign o_cpu_data   = i_ram_data;
    assign o_cpu_halt   = halt_q;
    assign o_dbg_rvalid = rvalid_q;
    assign o_dbg_rdata  = rdata_q;

    // Route the RAM port to the CPU, the granted host, or park it idle on the CPU bus.
    always_comb begin
        o_ram_address = i_cpu_address;
        o_ram_data    = i_cpu_data;
        o_ram_we      = 1'b0;
        o_ram_re      = 1'b0;
        if (cpuBusy) begin
            o_ram_we = i_cpu_wr_Ram;
            o_ram_re = i_cpu_rd_Ram;
        end else if (grant) begin
            o_ram_address = i_dbg_address;
            o_ram_data    = i_dbg_data;
            o_ram_we      = i_dbg_we;
            o_ram_re      = ~i_dbg_we;
        end
    end

    // Starvation tracking: count consecutive blocked host cycles and escalate to a halt.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_dbg_valid && cpuBusy) begin
                    cnt_d   = CntOne;
                    state_d = (CntOne == CntMax) ? S_HALT : S_STARVE;
                end
            end
            S_STARVE: begin
                if (grant || !i_dbg_valid) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
                    if (cnt_d == CntMax) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (!i_dbg_valid && !rdPend_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and the registered halt request that mirrors the next state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            halt_q  <= (state_d == S_HALT);
        end
    end

    // Host read pipeline: mark the granted read, capture RAM data a cycle later, pulse rvalid.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rdPend_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rdPend_q <= grant & ~i_dbg_we;
            rvalid_q <= rdPend_q;
            if (rdPend_q) begin
                rdata_q <= i_ram_data;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of who owns the RAM each cycle.
module tb_dm_arbiter;

    localparam int NbAddr  = 11;
    localparam int NbData  = 16;
    localparam int MaxWait = 8;

    logic              clk;
    logic              rstN;
    logic [NbAddr-1:0] cpuAddress;
    logic [NbData-1:0] cpuData;
    logic              cpuWr;
    logic              cpuRd;
    logic [NbData-1:0] cpuRdata;
    logic              cpuHalt;
    logic              dbgValid;
    logic              dbgWe;
    logic [NbAddr-1:0] dbgAddress;
    logic [NbData-1:0] dbgData;
    logic              dbgReady;
    logic              dbgRvalid;
    logic [NbData-1:0] dbgRdata;
    logic [NbAddr-1:0] ramAddress;
    logic [NbData-1:0] ramWdata;
    logic              ramWe;
    logic              ramRe;
    logic [NbData-1:0] ramRdata;

    dm_arbiter #(
        .NB_ADDRESS(NbAddr),
        .NB_DATA   (NbData),
        .MAX_WAIT  (MaxWait)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rstN),
        .i_cpu_address (cpuAddress),
        .i_cpu_data    (cpuData),
        .i_cpu_wr_Ram  (cpuWr),
        .i_cpu_rd_Ram  (cpuRd),
        .o_cpu_data    (cpuRdata),
        .o_cpu_halt    (cpuHalt),
        .i_dbg_valid   (dbgValid),
        .i_dbg_we      (dbgWe),
        .i_dbg_address (dbgAddress),
        .i_dbg_data    (dbgData),
        .o_dbg_ready   (dbgReady),
        .o_dbg_rvalid  (dbgRvalid),
        .o_dbg_rdata   (dbgRdata),
        .o_ram_address (ramAddress),
        .o_ram_data    (ramWdata),
        .o_ram_we      (ramWe),
        .o_ram_re      (ramRe),
        .i_ram_data    (ramRdata)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM sitting behind the arbiter.
    logic [NbData-1:0] ramMem [0:2047];
    always @(posedge clk) begin
        if (ramWe) ramMem[ramAddress] <= ramWdata;
        if (ramRe) ramRdata <= ramMem[ramAddress];
    end

    // Reference model state: expected memory contents, halt status,
    // length of the current blocked streak, and host reads in flight.
    typedef struct {
        int                due;
        logic [NbData-1:0] data;
    } rd_t;

    logic [NbData-1:0] shadow [0:2047];
    rd_t               rdQ[$];
    bit                mHalted;
    int                blocked;
    int                cyc;
    logic [NbData-1:0] lastRdata;

    int checks;
    int errors;

    // Compare one observed value against the model and report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs, check every output against the model, then advance the model.
    task automatic applyStimulus(input logic cw, input logic cr, input logic [NbAddr-1:0] ca,
                                 input logic [NbData-1:0] cd, input logic dv, input logic dw,
                                 input logic [NbAddr-1:0] da, input logic [NbData-1:0] dd);
        bit                cpuAct;
        bit                expReady;
        bit                expWe;
        bit                expRe;
        bit                expRv;
        bit                pendingOld;
        logic [NbAddr-1:0] expAddr;
        logic [NbData-1:0] expData;
        logic [NbData-1:0] expRdata;

        cpuWr      = cw;
        cpuRd      = cr;
        cpuAddress = ca;
        cpuData    = cd;
        dbgValid   = dv;
        dbgWe      = dw;
        dbgAddress = da;
        dbgData    = dd;
        #2;

        cpuAct   = (cw || cr) && !mHalted;
        expReady = dv && !cpuAct;
        expAddr  = ca;
        expData  = cd;
        expWe    = 1'b0;
        expRe    = 1'b0;
        if (cpuAct) begin
            expWe = cw;
            expRe = cr;
        end else if (expReady) begin
            expAddr = da;
            expData = dd;
            expWe   = dw;
            expRe   = !dw;
        end
        expRv    = (rdQ.size() > 0) && (rdQ[0].due == cyc);
        expRdata = expRv ? rdQ[0].data : lastRdata;

        checkOutput("ready",   32'(dbgReady),   32'(expReady));
        checkOutput("halt",    32'(cpuHalt),    32'(mHalted));
        checkOutput("ram_we",  32'(ramWe),      32'(expWe));
        checkOutput("ram_re",  32'(ramRe),      32'(expRe));
        checkOutput("ram_adr", 32'(ramAddress), 32'(expAddr));
        checkOutput("ram_dat", 32'(ramWdata),   32'(expData));
        checkOutput("rvalid",  32'(dbgRvalid),  32'(expRv));
        checkOutput("rdata",   32'(dbgRdata),   32'(expRdata));

        if (expRv) begin
            lastRdata = rdQ[0].data;
            void'(rdQ.pop_front());
        end

        @(posedge clk);

        pendingOld = 1'b0;
        foreach (rdQ[i]) begin
            if (rdQ[i].due == cyc + 1) pendingOld = 1'b1;
        end
        if (expReady && !dw) rdQ.push_back('{cyc + 2, shadow[da]});
        if (expWe) shadow[expAddr] = expData;

        if (mHalted) begin
            if (!dv && !pendingOld) begin
                mHalted = 1'b0;
                blocked = 0;
            end
        end else if (dv && !expReady) begin
            blocked++;
            if (blocked >= MaxWait) mHalted = 1'b1;
        end else begin
            blocked = 0;
        end

        cyc++;
        #1;
    endtask

    // Hold reset low for one full cycle starting just after a clock edge.
    task automatic resetPulse();
        cpuWr    = 1'b0;
        cpuRd    = 1'b0;
        dbgValid = 1'b0;
        rstN     = 1'b0;
        #1;
        mHalted   = 1'b0;
        blocked   = 0;
        lastRdata = '0;
        rdQ.delete();
        checkOutput("rst_halt",   32'(cpuHalt),   32'(0));
        checkOutput("rst_rvalid", 32'(dbgRvalid), 32'(0));
        checkOutput("rst_rdata",  32'(dbgRdata),  32'(0));
        @(posedge clk);
        cyc++;
        #1;
        rstN = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        int busyPct;

        checks    = 0;
        errors    = 0;
        cyc       = 0;
        mHalted   = 1'b0;
        blocked   = 0;
        lastRdata = '0;
        ramRdata  = '0;
        for (int i = 0; i < 2048; i++) begin
            ramMem[i] = '0;
            shadow[i] = '0;
        end

        rstN       = 1'b0;
        cpuWr      = 1'b0;
        cpuRd      = 1'b0;
        cpuAddress = '0;
        cpuData    = '0;
        dbgValid   = 1'b0;
        dbgWe      = 1'b0;
        dbgAddress = '0;
        dbgData    = '0;
        #3;
        checkOutput("init_halt",   32'(cpuHalt),   32'(0));
        checkOutput("init_rvalid", 32'(dbgRvalid), 32'(0));
        checkOutput("init_rdata",  32'(dbgRdata),  32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Idle CPU: host write then read back.
        applyStimulus(0, 0, '0, '0, 1, 1, 11'h0A5, 16'h1234);
        applyStimulus(0, 0, '0, '0, 1, 0, 11'h0A5, 16'h0000);
        idle(3);
        checkOutput("t1_rdata", 32'(dbgRdata), 32'h1234);

        // Simultaneous CPU and host write to the same word.
        applyStimulus(1, 0, 11'h010, 16'hBEEF, 1, 1, 11'h010, 16'h5555);
        applyStimulus(0, 0, 11'h010, 16'h0000, 1, 1, 11'h010, 16'h5555);
        applyStimulus(0, 0, '0, '0, 1, 0, 11'h010, '0);
        idle(3);
        checkOutput("t2_rdata", 32'(dbgRdata), 32'h5555);

        // Sustained CPU traffic starves the host until the CPU is frozen.
        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 11'h020, 16'h0F0F, 1, 0, 11'h0A5, '0);
        checkOutput("t3_halted", 32'(cpuHalt), 32'(1));
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 11'h020, 16'h0F0F, 0, 0, '0, '0);
        checkOutput("t3_released", 32'(cpuHalt), 32'(0));
        idle(2);

        // Preload and four back-to-back reads.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, '0, 1, 1, NbAddr'(i), NbData'(i + 1));
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, '0, 1, 0, NbAddr'(i), '0);
        idle(3);
        checkOutput("t4_last", 32'(dbgRdata), 32'h4);

        // Reset between read grant and rvalid drops the read.
        applyStimulus(0, 0, '0, '0, 1, 0, 11'h0A5, '0);
        resetPulse();
        idle(3);

        // Host gives up during starvation: no halt.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 11'h030, '0, 1, 1, 11'h031, 16'h7777);
        applyStimulus(0, 1, 11'h030, '0, 0, 0, '0, '0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 11'h030, '0, 1, 1, 11'h031, 16'h7777);
        checkOutput("t6_nohalt", 32'(cpuHalt), 32'(0));
        idle(2);

        // Reset while halted drops the freeze immediately.
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 11'h040, '0, 1, 0, 11'h041, '0);
        checkOutput("halt_before_rst", 32'(cpuHalt), 32'(1));
        resetPulse();
        idle(2);

        // Randomized traffic in phases of differing CPU load.
        busyPct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 25 == 0) begin
                case ($urandom_range(0, 2))
                    0:       busyPct = 10;
                    1:       busyPct = 50;
                    default: busyPct = 95;
                endcase
            end
            begin
                bit cBusy;
                bit cw;
                cBusy = ($urandom_range(0, 99) < busyPct);
                cw    = $urandom_range(0, 1);
                applyStimulus(cBusy && cw, cBusy && !cw, NbAddr'($urandom_range(0, 15)),
                              NbData'($urandom), ($urandom_range(0, 99) < 75),
                              $urandom_range(0, 1), NbAddr'($urandom_range(0, 15)),
                              NbData'($urandom));
            end
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
